pb_pkt_builder: RTL and testbench

Packet builder stage that sits directly upstream of the packet parser. On a start pulse it reads N = byte_cnt+1 raw payload bytes from a source memory and writes a framed packet into inmem at addr_hdr: a 16-bit header with SOP, ECC msb, pkt_type, byte_cnt and a Hamming ECC code, then the payload, then a CRC-8 byte. The parser later consumes this frame. Optional error injection produces ECC and CRC faults so the parser's error paths can be exercised end to end.

---
 rtl/pb_pkg.sv | 47 ++++
 rtl/pb_pkt_builder_if.sv | 28 ++
 rtl/crc8_byte_calc.sv | 18 +
 rtl/pb_pkt_builder.sv | 146 ++++++++++++++
 tb/tb_pb_pkt_builder.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pb_pkg.sv
// Shared types and header helpers for the packet builder.
package pb_pkg;

  localparam int         ADDR_W_DEF = 14;
  localparam logic [2:0] SOP_DEF    = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CRC,
    DONE
  } pb_state_e;

  typedef enum logic [1:0] {
    ECC_INJ_NONE = 2'b00,
    ECC_INJ_B4   = 2'b01,
    ECC_INJ_B48  = 2'b10,
    ECC_INJ_OFF  = 2'b11
  } pb_ecc_inj_e;

  // Returns {xor of all d bits, p3, p2, p1, p0}
  function automatic logic [4:0] hdr_ecc(
    input logic [7:0] d
  );
    logic p0, p1, p2, p3;
    p0 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p1 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p2 = d[1] ^ d[2] ^ d[3] ^ d[7];
    p3 = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {^d, p3, p2, p1, p0};
  endfunction

  function automatic logic [15:0] inj_mask(
    input logic [1:0] inj
  );
    logic [15:0] m;
    m = '0;
    unique case (1'b1)
      (inj == ECC_INJ_B4):  m = 16'h0010;
      (inj == ECC_INJ_B48): m = 16'h0110;
      default:              m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pb_pkt_builder_if.sv
// Memory-side bundle: source read port and inmem write port.
interface pb_pkt_builder_if #(
  parameter int ADDR_W = 14
);

  logic [ADDR_W-1:0] src_addr;
  logic [31:0]       src_data_o;
  logic [ADDR_W-1:0] inmem_addr;
  logic [31:0]       inmem_data_i;
  logic [3:0]        inmem_we;

  modport master (
    output src_addr,
    input  src_data_o,
    output inmem_addr,
    output inmem_data_i,
    output inmem_we
  );

  modport slave (
    input  src_addr,
    output src_data_o,
    input  inmem_addr,
    input  inmem_data_i,
    input  inmem_we
  );

endinterface

// File: rtl/crc8_byte_calc.sv
// One-byte CRC-8 step, poly 0x07, MSB first.
module crc8_byte_calc (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  always_comb begin
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
      else      c = {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/pb_pkt_builder.sv
// Builds a framed packet (header, payload, CRC-8) into inmem
// from raw source bytes, with optional ECC/CRC fault injection.
module pb_pkt_builder
  import pb_pkg::*;
#(
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter logic [2:0] SOP_VAL = SOP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pb_start,
  input  logic [ADDR_W-1:0] pb_addr_in,
  input  logic [ADDR_W-1:0] pb_addr_hdr,
  input  logic [3:0]        pb_byte_cnt,
  input  logic [3:0]        pb_pkt_type,
  input  logic [1:0]        pb_ecc_inj,
  input  logic              pb_crc_inj,
  output logic              pb_busy,
  output logic              pb_irq,
  pb_pkt_builder_if.master  mem
);

  pb_state_e r_state;
  pb_state_e w_next;

  logic [ADDR_W-1:0] r_addr_in;
  logic [ADDR_W-1:0] r_addr_hdr;
  logic [3:0]        r_byte_cnt;
  logic [3:0]        r_pkt_type;
  logic [1:0]        r_ecc_inj;
  logic              r_crc_inj;
  logic [3:0]        r_k;
  logic [7:0]        r_crc;

  logic              w_accept;
  logic              w_last;
  logic [7:0]        w_byte;
  logic [7:0]        w_crc_next;
  logic [4:0]        w_ecc;
  logic [15:0]       w_hdr;
  logic              w_unused;

  assign w_accept = (r_state == IDLE) && pb_start;
  assign w_last   = (r_k == r_byte_cnt);
  assign w_byte   = mem.src_data_o[7:0];
  assign w_unused = ^mem.src_data_o[31:8];

  // ECC fields always describe the clean header; faults go on top
  assign w_ecc = hdr_ecc({r_pkt_type, r_byte_cnt});
  assign w_hdr = {SOP_VAL, w_ecc[4], r_pkt_type,
                  r_byte_cnt, w_ecc[3:0]}
               ^ inj_mask(r_ecc_inj);

  crc8_byte_calc u_crc (
    .crc_in  (r_crc),
    .data_in (w_byte),
    .crc_out (w_crc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr_in  <= '0;
      r_addr_hdr <= '0;
      r_byte_cnt <= '0;
      r_pkt_type <= '0;
      r_ecc_inj  <= '0;
      r_crc_inj  <= 1'b0;
      r_k        <= '0;
      r_crc      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr_in  <= pb_addr_in;
        r_addr_hdr <= pb_addr_hdr;
        r_byte_cnt <= pb_byte_cnt;
        r_pkt_type <= pb_pkt_type;
        r_ecc_inj  <= pb_ecc_inj;
        r_crc_inj  <= pb_crc_inj;
      end
      unique case (r_state)
        HDR: begin
          r_crc <= '0;
          r_k   <= '0;
        end
        DATA: begin
          r_crc <= w_crc_next;
          r_k   <= r_k + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    pb_busy          = 1'b1;
    pb_irq           = 1'b0;
    mem.src_addr     = '0;
    mem.inmem_addr   = '0;
    mem.inmem_data_i = '0;
    mem.inmem_we     = '0;
    unique case (r_state)
      IDLE: begin
        pb_busy = 1'b0;
        if (pb_start) w_next = HDR;
      end
      HDR: begin
        mem.inmem_addr   = r_addr_hdr;
        mem.inmem_we     = 4'b0011;
        mem.inmem_data_i = {16'h0, w_hdr};
        mem.src_addr     = r_addr_in;
        w_next           = DATA;
      end
      DATA: begin
        mem.inmem_addr   = r_addr_hdr
                         + ADDR_W'(2)
                         + ADDR_W'(r_k);
        mem.inmem_we     = 4'b0001;
        mem.inmem_data_i = {24'h0, w_byte};
        // prefetch next byte; source has one cycle latency
        if (!w_last)
          mem.src_addr = r_addr_in
                       + ADDR_W'(r_k)
                       + ADDR_W'(1);
        else
          w_next = CRC;
      end
      CRC: begin
        mem.inmem_addr   = r_addr_hdr
                         + ADDR_W'(r_byte_cnt)
                         + ADDR_W'(3);
        mem.inmem_we     = 4'b0001;
        mem.inmem_data_i = {24'h0,
                            r_crc ^ {7'h0, r_crc_inj}};
        w_next           = DONE;
      end
      DONE: begin
        pb_irq = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pb_pkt_builder.sv
// Randomized self-checking bench for pb_pkt_builder.
module tb_pb_pkt_builder;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          pb_start;
  logic [AW-1:0] pb_addr_in;
  logic [AW-1:0] pb_addr_hdr;
  logic [3:0]    pb_byte_cnt;
  logic [3:0]    pb_pkt_type;
  logic [1:0]    pb_ecc_inj;
  logic          pb_crc_inj;
  logic          pb_busy;
  logic          pb_irq;

  int n_cmp = 0;
  int n_bad = 0;

  pb_pkt_builder_if #(.ADDR_W(AW)) mem ();

  pb_pkt_builder #(
    .ADDR_W  (AW),
    .SOP_VAL (3'b101)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pb_start    (pb_start),
    .pb_addr_in  (pb_addr_in),
    .pb_addr_hdr (pb_addr_hdr),
    .pb_byte_cnt (pb_byte_cnt),
    .pb_pkt_type (pb_pkt_type),
    .pb_ecc_inj  (pb_ecc_inj),
    .pb_crc_inj  (pb_crc_inj),
    .pb_busy     (pb_busy),
    .pb_irq      (pb_irq),
    .mem         (mem)
  );

  // Source memory: one-cycle read latency, junk in upper lanes
  logic [7:0]  src_mem [0:(1<<AW)-1];
  logic [31:0] junk;
  always @(posedge clk) begin
    junk = $urandom;
    mem.src_data_o <= {junk[31:8], src_mem[mem.src_addr]};
  end

  function automatic logic [15:0] model_hdr(
    input logic [3:0] typ,
    input logic [3:0] cnt,
    input logic [1:0] inj
  );
    logic [7:0]  d;
    logic [3:0]  ecc;
    logic [15:0] h;
    d      = {typ, cnt};
    ecc[0] = ^(d & 8'h5B);
    ecc[1] = ^(d & 8'h6D);
    ecc[2] = ^(d & 8'h8E);
    ecc[3] = ^(d & 8'hF0);
    h = {3'b101, ^d, typ, cnt, ecc};
    if (inj == 2'b01) h = h ^ 16'h0010;
    if (inj == 2'b10) h = h ^ 16'h0110;
    return h;
  endfunction

  // Remainder of message * x^8 modulo x^8+x^2+x+1
  function automatic logic [7:0] model_crc(
    input logic [7:0] q[$]
  );
    logic [8:0] r;
    r = '0;
    for (int i = 0; i <= q.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        logic bi;
        bi = (i < q.size()) ? q[i][b] : 1'b0;
        r  = {r[7:0], bi};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  task automatic run_pkt(
    input logic [AW-1:0] a_in,
    input logic [AW-1:0] a_hdr,
    input logic [3:0]    cnt,
    input logic [3:0]    typ,
    input logic [1:0]    ei,
    input logic          ci,
    input int            extra1,
    input int            extra2,
    input string         tag
  );
    logic [21:0]   exp_q[$];
    logic [21:0]   got_q[$];
    logic [7:0]    pl[$];
    logic [15:0]   hdr;
    logic [7:0]    crc;
    logic [AW-1:0] ad;
    int n, irq_cnt, irq_cyc, busy_bad, lane_bad, m;
    n = int'(cnt) + 1;
    irq_cnt = 0; irq_cyc = -1;
    busy_bad = 0; lane_bad = 0;
    hdr = model_hdr(typ, cnt, ei);
    ad = a_hdr;
    exp_q.push_back({ad, hdr[7:0]});
    ad = a_hdr + AW'(1);
    exp_q.push_back({ad, hdr[15:8]});
    for (int k = 0; k < n; k++) begin
      ad = a_in + AW'(k);
      pl.push_back(src_mem[ad]);
      ad = a_hdr + AW'(k + 2);
      exp_q.push_back({ad, src_mem[a_in + AW'(k)]});
    end
    crc = model_crc(pl) ^ {7'h0, ci};
    ad = a_hdr + AW'(n + 2);
    exp_q.push_back({ad, crc});

    @(negedge clk);
    pb_addr_in  = a_in;
    pb_addr_hdr = a_hdr;
    pb_byte_cnt = cnt;
    pb_pkt_type = typ;
    pb_ecc_inj  = ei;
    pb_crc_inj  = ci;
    pb_start    = 1'b1;
    @(negedge clk);
    pb_start    = 1'b0;
    pb_addr_in  = AW'($urandom);
    pb_addr_hdr = AW'($urandom);
    pb_byte_cnt = 4'($urandom);
    pb_pkt_type = 4'($urandom);
    pb_ecc_inj  = 2'($urandom);
    pb_crc_inj  = 1'($urandom);
    for (int c = 1; c <= n + 8; c++) begin
      if (pb_busy !== (c <= n + 3)) busy_bad++;
      if (pb_irq === 1'b1) begin
        irq_cnt++;
        irq_cyc = c;
      end
      for (int j = 0; j < 4; j++) begin
        if (mem.inmem_we[j] === 1'b1) begin
          ad = mem.inmem_addr + AW'(j);
          got_q.push_back({ad, mem.inmem_data_i[8*j +: 8]});
        end else if (mem.inmem_data_i[8*j +: 8] !== 8'h00) begin
          lane_bad++;
        end
      end
      pb_start = (c == extra1) || (c == extra2);
      @(negedge clk);
    end
    pb_start = 1'b0;

    n_cmp++;
    if (irq_cnt !== 1) begin
      n_bad++;
      $display("FAIL %s irq_count: got %0d want 1", tag, irq_cnt);
    end
    n_cmp++;
    if (irq_cyc !== n + 3) begin
      n_bad++;
      $display("FAIL %s irq_cycle: got %0d want %0d",
               tag, irq_cyc, n + 3);
    end
    n_cmp++;
    if (busy_bad !== 0) begin
      n_bad++;
      $display("FAIL %s busy: got %0d bad cycles want 0",
               tag, busy_bad);
    end
    n_cmp++;
    if (lane_bad !== 0) begin
      n_bad++;
      $display("FAIL %s idle_lanes: got %0d nonzero want 0",
               tag, lane_bad);
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d want %0d",
               tag, got_q.size(), exp_q.size());
    end
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s wr[%0d] addr/data: got %h/%h want %h/%h",
                 tag, i, got_q[i][21:8], got_q[i][7:0],
                 exp_q[i][21:8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pb_busy, pb_irq} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_busy_irq: got %b want 00", {pb_busy, pb_irq});
    end
    n_cmp++;
    if (mem.inmem_we !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_we: got %h want 0", mem.inmem_we);
    end
    n_cmp++;
    if ({mem.inmem_addr, mem.inmem_data_i, mem.src_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_buses: got %h/%h/%h want 0",
               mem.inmem_addr, mem.inmem_data_i, mem.src_addr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_pkt(14'h0200, 14'h0010, 4'h2, 4'h3, 2'b00, 1'b0, 0, 0, "basic");
  endtask

  task automatic test_single_byte();
    src_mem[14'h0300] = 8'h01;
    run_pkt(14'h0300, 14'h0040, 4'h0, 4'h5, 2'b00, 1'b0, 0, 0, "one_01");
    src_mem[14'h0300] = 8'h00;
    run_pkt(14'h0300, 14'h0080, 4'h0, 4'h5, 2'b00, 1'b0, 0, 0, "one_00");
  endtask

  task automatic test_injection();
    run_pkt(14'h0200, 14'h0010, 4'h2, 4'h3, 2'b01, 1'b0, 0, 0, "ecc01");
    run_pkt(14'h0200, 14'h0010, 4'h2, 4'h3, 2'b10, 1'b0, 0, 0, "ecc10");
    run_pkt(14'h0200, 14'h0010, 4'h2, 4'h3, 2'b11, 1'b0, 0, 0, "ecc11");
    run_pkt(14'h0200, 14'h0010, 4'h2, 4'h3, 2'b00, 1'b1, 0, 0, "crcinj");
  endtask

  task automatic test_wrap();
    run_pkt(14'h0500, 14'h3FFE, 4'h1, 4'h9, 2'b00, 1'b0, 0, 0, "wrap_hdr");
    run_pkt(14'h3FFE, 14'h1000, 4'h4, 4'hA, 2'b00, 1'b0, 0, 0, "wrap_src");
  endtask

  task automatic test_busy_start();
    run_pkt(14'h0700, 14'h0900, 4'h3, 4'h6, 2'b00, 1'b0, 3, 7, "busy_start");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    pb_addr_in  = 14'h0A00;
    pb_addr_hdr = 14'h0B00;
    pb_byte_cnt = 4'h7;
    pb_pkt_type = 4'h2;
    pb_ecc_inj  = 2'b00;
    pb_crc_inj  = 1'b0;
    pb_start    = 1'b1;
    @(negedge clk);
    pb_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem.inmem_we !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_mid_we: got %h want 0", mem.inmem_we);
    end
    n_cmp++;
    if (pb_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_busy: got %b want 0", pb_busy);
    end
    n_cmp++;
    if (pb_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_irq: got %b want 0", pb_irq);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({pb_busy, mem.inmem_we} !== 5'h0) begin
      n_bad++;
      $display("FAIL rst_mid_after: got %b want 0",
               {pb_busy, mem.inmem_we});
    end
    run_pkt(14'h0A00, 14'h0B00, 4'h7, 4'h2, 2'b00, 1'b0, 0, 0, "rst_rerun");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      run_pkt(AW'($urandom), AW'($urandom), 4'($urandom),
              4'($urandom), 2'($urandom), 1'($urandom),
              0, 0, $sformatf("rand%0d", t));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) src_mem[i] = 8'($urandom);
    pb_start    = 1'b0;
    pb_addr_in  = '0;
    pb_addr_hdr = '0;
    pb_byte_cnt = '0;
    pb_pkt_type = '0;
    pb_ecc_inj  = '0;
    pb_crc_inj  = 1'b0;
    test_reset();
    test_basic();
    test_single_byte();
    test_injection();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
